spi_master: RTL and testbench

- Host-side SPI transaction engine that sits directly upstream of the SPI memory block.
- It drives that block's sclk_pin, cs_pin and mosi_pin and samples its miso_pin.
- It converts a parallel command (read/write, 7-bit address, 8-bit write data) into one 16-bit SPI frame and returns read data in parallel.
- Used by on-chip test logic and by benches in place of hand-toggled pins.

---
 rtl/spi_master.sv | 159 +++++++++++++++
 tb/tb_spi_master.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// spi_master: host-side SPI mode-0 transaction engine.
// Sends one 16-bit frame {addr[6:0], rw, data[7:0]} MSB first. For reads,
// the last 8 bits are captured from miso and returned on rdata.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   start, rw, addr, wdata command; accepted only while idle
//   busy, done, rdata      status and read data
//   sclk_pin, cs_pin, mosi_pin, miso_pin  SPI pins
// All pin outputs come straight from flops. Each state's branch assigns the
// pin values for the following cycle, so the pins trail the state register
// by one cycle.
module spi_master #(
  parameter int unsigned HALF_PERIOD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk_pin,
  output logic       cs_pin,
  output logic       mosi_pin,
  input  logic       miso_pin
);

  localparam int unsigned CNT_W = $clog2(HALF_PERIOD + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             high_half;
  logic [3:0]       bit_cnt;
  logic [15:0]      shreg;
  logic [7:0]       rx_byte;
  logic             rw_q;
  logic             half_end;

  // Last clk cycle of the current half-period.
  assign half_end = (cnt == CNT_LAST);

  // Transaction sequencer and registered pin drivers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      high_half <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_byte   <= '0;
      rw_q      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= 8'h00;
      sclk_pin  <= 1'b0;
      cs_pin    <= 1'b1;
      mosi_pin  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cs_pin   <= 1'b1;
          sclk_pin <= 1'b0;
          mosi_pin <= 1'b0;
          busy     <= 1'b0;
          cnt      <= '0;
          if (start) begin
            rw_q      <= rw;
            shreg     <= {addr, rw, (rw ? 8'h00 : wdata)};
            rx_byte   <= '0;
            bit_cnt   <= '0;
            high_half <= 1'b0;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end

        SETUP: begin
          cs_pin   <= 1'b0;
          sclk_pin <= 1'b0;
          mosi_pin <= shreg[15];
          cnt      <= half_end ? '0 : cnt + CNT_W'(1);
          if (half_end) begin
            high_half <= 1'b0;
            bit_cnt   <= '0;
            state     <= SHIFT;
          end
        end

        SHIFT: begin
          cs_pin   <= 1'b0;
          sclk_pin <= high_half;
          mosi_pin <= shreg[15];
          cnt      <= half_end ? '0 : cnt + CNT_W'(1);
          if (half_end) begin
            if (!high_half) begin
              high_half <= 1'b1;
            end else begin
              // End of a high half: advance mosi and capture the data-phase miso.
              high_half <= 1'b0;
              shreg     <= {shreg[14:0], 1'b0};
              if (rw_q && bit_cnt[3]) begin
                rx_byte <= {rx_byte[6:0], miso_pin};
              end
              if (bit_cnt == 4'd15) begin
                state <= HOLD;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
        end

        HOLD: begin
          cs_pin   <= 1'b0;
          sclk_pin <= 1'b0;
          mosi_pin <= 1'b0;
          cnt      <= half_end ? '0 : cnt + CNT_W'(1);
          if (half_end) begin
            state <= DONE;
          end
        end

        DONE: begin
          cs_pin   <= 1'b1;
          sclk_pin <= 1'b0;
          mosi_pin <= 1'b0;
          cnt      <= half_end ? '0 : cnt + CNT_W'(1);
          if (cnt == '0) begin
            done <= 1'b1;
            if (rw_q) begin
              rdata <= rx_byte;
            end
          end
          if (half_end) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed self-checking bench for spi_master (HALF_PERIOD=2),
// with a behavioural SPI memory slave on the pins.
module tb_spi_master;

  localparam int unsigned HP  = 2;
  localparam int          LAT = 34 * HP + 1;
  localparam int          CSL = 34 * HP;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       start    = 1'b0;
  logic       rw       = 1'b0;
  logic [6:0] addr     = '0;
  logic [7:0] wdata    = '0;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       sclk_pin;
  logic       cs_pin;
  logic       mosi_pin;
  logic       miso_pin;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  // Pin monitor state
  int          mon_edges    = 0;
  int          cs_low_total = 0;
  int          done_total   = 0;
  logic [15:0] mon_frame    = '0;
  logic        mon_prev     = 1'b0;

  // Memory slave state
  logic        mdl_init = 1'b1;
  logic [7:0]  mem [128];
  int          sl_bits  = 0;
  logic [15:0] sl_sr    = '0;
  logic [6:0]  sl_addr  = '0;
  logic        sl_rd    = 1'b0;
  logic [7:0]  sl_out   = '0;
  logic        sl_prev  = 1'b0;

  spi_master #(.HALF_PERIOD(HP)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rw       (rw),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .sclk_pin (sclk_pin),
    .cs_pin   (cs_pin),
    .mosi_pin (mosi_pin),
    .miso_pin (miso_pin)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Counts sclk rising edges, mosi at those edges, cs-low cycles, done pulses.
  always @(negedge clk) begin
    if (sclk_pin && !mon_prev) begin
      mon_frame <= {mon_frame[14:0], mosi_pin};
      mon_edges <= mon_edges + 1;
    end
    if (!cs_pin) cs_low_total <= cs_low_total + 1;
    if (done === 1'b1) done_total <= done_total + 1;
    mon_prev <= sclk_pin;
  end

  // SPI memory: 7-bit address + rw, then data; read bits change after sclk falls.
  always @(negedge clk) begin
    if (mdl_init) begin
      for (int i = 0; i < 128; i++) mem[i] = 8'h00;
      mem[7'h15] = 8'h3C;
      sl_bits  = 0;
      sl_rd    = 1'b0;
      miso_pin = 1'b0;
    end else if (cs_pin) begin
      sl_bits  = 0;
      miso_pin = 1'b0;
    end else begin
      if (sclk_pin && !sl_prev) begin
        sl_sr   = {sl_sr[14:0], mosi_pin};
        sl_bits = sl_bits + 1;
        if (sl_bits == 8) begin
          sl_addr = sl_sr[7:1];
          sl_rd   = sl_sr[0];
          sl_out  = mem[sl_addr];
        end
        if (sl_bits == 16 && !sl_rd) mem[sl_addr] = sl_sr[7:0];
      end
      if (!sclk_pin && sl_prev && sl_rd && sl_bits >= 8 && sl_bits < 16)
        miso_pin = sl_out[3'(15 - sl_bits)];
    end
    sl_prev = sclk_pin;
  end

  task automatic pulse_start(input logic r, input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    rw = r; addr = a; wdata = d; start = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    start   = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat, output bit ok);
    ok  = 1'b0;
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok  = 1'b1;
        lat = cyc - acc_cyc;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; mdl_init = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (cs_pin !== 1'b1) begin failures++; $display("FAIL reset_cs got=%b exp=1", cs_pin); end
    checks++; if (sclk_pin !== 1'b0) begin failures++; $display("FAIL reset_sclk got=%b exp=0", sclk_pin); end
    checks++; if (mosi_pin !== 1'b0) begin failures++; $display("FAIL reset_mosi got=%b exp=0", mosi_pin); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
    reset = 1'b0; mdl_init = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write;
    int e0, c0, d0, lat;
    bit ok;
    e0 = mon_edges; c0 = cs_low_total; d0 = done_total;
    pulse_start(1'b0, 7'h15, 8'hA5);
    wait_done(200, lat, ok);
    checks++; if (!ok || lat != LAT) begin failures++; $display("FAIL write_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL write_rdata got=%h exp=00", rdata); end
    repeat (HP + 3) @(negedge clk);
    checks++; if (mon_edges - e0 != 16) begin failures++; $display("FAIL write_edges got=%0d exp=16", mon_edges - e0); end
    checks++; if (mon_frame !== 16'h2AA5) begin failures++; $display("FAIL write_frame got=%h exp=2aa5", mon_frame); end
    checks++; if (cs_low_total - c0 != CSL) begin failures++; $display("FAIL write_cs_low got=%0d exp=%0d", cs_low_total - c0, CSL); end
    checks++; if (done_total - d0 != 1) begin failures++; $display("FAIL write_done_count got=%0d exp=1", done_total - d0); end
  endtask

  task automatic test_read;
    int e0, lat;
    bit ok;
    @(negedge clk); mdl_init = 1'b1;
    repeat (2) @(negedge clk); mdl_init = 1'b0;
    e0 = mon_edges;
    pulse_start(1'b1, 7'h15, 8'hFF);
    wait_done(200, lat, ok);
    checks++; if (!ok || lat != LAT) begin failures++; $display("FAIL read_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (rdata !== 8'h3C) begin failures++; $display("FAIL read_rdata got=%h exp=3c", rdata); end
    repeat (HP + 3) @(negedge clk);
    checks++; if (mon_edges - e0 != 16) begin failures++; $display("FAIL read_edges got=%0d exp=16", mon_edges - e0); end
    checks++; if (mon_frame !== 16'h2B00) begin failures++; $display("FAIL read_frame got=%h exp=2b00", mon_frame); end
  endtask

  task automatic test_loop;
    int lat;
    bit ok;
    pulse_start(1'b0, 7'h03, 8'h5A);
    wait_done(200, lat, ok);
    checks++; if (!ok) begin failures++; $display("FAIL loop_write_done got=timeout exp=done"); end
    repeat (HP + 3) @(negedge clk);
    pulse_start(1'b1, 7'h03, 8'h00);
    wait_done(200, lat, ok);
    checks++; if (!ok || lat != LAT) begin failures++; $display("FAIL loop_read_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (rdata !== 8'h5A) begin failures++; $display("FAIL loop_rdata got=%h exp=5a", rdata); end
    repeat (HP + 3) @(negedge clk);
    checks++; if (mon_frame !== 16'h0700) begin failures++; $display("FAIL loop_read_frame got=%h exp=0700", mon_frame); end
  endtask

  task automatic test_ignore;
    int e0, c0, d0, lat;
    bit ok;
    e0 = mon_edges; c0 = cs_low_total; d0 = done_total;
    pulse_start(1'b0, 7'h11, 8'hC3);
    repeat (9) @(negedge clk);
    rw = 1'b1; addr = 7'h7F; wdata = 8'h00; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(200, lat, ok);
    checks++; if (!ok || lat != LAT) begin failures++; $display("FAIL ignore_latency got=%0d exp=%0d", lat, LAT); end
    repeat (40) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ignore_busy_after got=%b exp=0", busy); end
    checks++; if (mon_edges - e0 != 16) begin failures++; $display("FAIL ignore_edges got=%0d exp=16", mon_edges - e0); end
    checks++; if (mon_frame !== 16'h22C3) begin failures++; $display("FAIL ignore_frame got=%h exp=22c3", mon_frame); end
    checks++; if (cs_low_total - c0 != CSL) begin failures++; $display("FAIL ignore_cs_low got=%0d exp=%0d", cs_low_total - c0, CSL); end
    checks++; if (done_total - d0 != 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", done_total - d0); end
    checks++; if (rdata !== 8'h5A) begin failures++; $display("FAIL ignore_rdata got=%h exp=5a", rdata); end
  endtask

  task automatic test_reset_mid;
    int e0, d0, rises, lat;
    bit ok, prev, found;
    d0 = done_total;
    pulse_start(1'b0, 7'h7F, 8'hFF);
    rises = 0; prev = 1'b0; found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sclk_pin && !prev) rises++;
      prev = sclk_pin;
      if (rises == 6) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin failures++; $display("FAIL mid_reach_bit6 got=%0d exp=6", rises); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (cs_pin !== 1'b1) begin failures++; $display("FAIL mid_cs got=%b exp=1", cs_pin); end
    checks++; if (sclk_pin !== 1'b0) begin failures++; $display("FAIL mid_sclk got=%b exp=0", sclk_pin); end
    checks++; if (mosi_pin !== 1'b0) begin failures++; $display("FAIL mid_mosi got=%b exp=0", mosi_pin); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
    checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL mid_rdata got=%h exp=00", rdata); end
    reset = 1'b0;
    repeat (100) @(negedge clk);
    checks++; if (done_total != d0) begin failures++; $display("FAIL mid_no_done got=%0d exp=%0d", done_total, d0); end
    e0 = mon_edges;
    pulse_start(1'b0, 7'h2A, 8'h81);
    wait_done(200, lat, ok);
    checks++; if (!ok || lat != LAT) begin failures++; $display("FAIL mid_new_latency got=%0d exp=%0d", lat, LAT); end
    repeat (HP + 3) @(negedge clk);
    checks++; if (mon_edges - e0 != 16) begin failures++; $display("FAIL mid_new_edges got=%0d exp=16", mon_edges - e0); end
    checks++; if (mon_frame !== 16'h5481) begin failures++; $display("FAIL mid_new_frame got=%h exp=5481", mon_frame); end
  endtask

  task automatic test_back_to_back;
    int e0, d0, d, gap;
    bit gap_done;
    logic [15:0] frame_a, frame_b;
    e0 = mon_edges; d0 = done_total;
    d = 0; gap = 0; gap_done = 1'b0; frame_a = '0; frame_b = '0;
    @(negedge clk);
    rw = 1'b0; addr = 7'h15; wdata = 8'h0F; start = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      if (i == 5) wdata = 8'hF0;
      if (done === 1'b1) begin
        d++;
        if (d == 1) frame_a = mon_frame;
        else begin
          frame_b = mon_frame;
          start   = 1'b0;
        end
      end
      if (d >= 1 && !gap_done) begin
        if (cs_pin) gap++;
        else gap_done = 1'b1;
      end
    end
    start = 1'b0;
    checks++; if (d != 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", d); end
    checks++; if (!gap_done || gap < int'(HP + 1)) begin failures++; $display("FAIL b2b_cs_gap got=%0d exp>=%0d", gap, HP + 1); end
    checks++; if (frame_a !== 16'h2A0F) begin failures++; $display("FAIL b2b_frame_a got=%h exp=2a0f", frame_a); end
    checks++; if (frame_b !== 16'h2AF0) begin failures++; $display("FAIL b2b_frame_b got=%h exp=2af0", frame_b); end
    checks++; if (mon_edges - e0 != 32) begin failures++; $display("FAIL b2b_edges got=%0d exp=32", mon_edges - e0); end
    checks++; if (done_total - d0 != 2) begin failures++; $display("FAIL b2b_done_total got=%0d exp=2", done_total - d0); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_loop();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
